// File: rtl/dmem_ctrl.sv
// Data-memory controller: decodes CPU addresses against BASE, performs byte/half/word
// stores and sign/zero-extended loads with LATENCY wait states, and flags bad accesses.
module dmem_ctrl #(
  parameter logic [31:0] BASE    = 32'h1001_0000,
  parameter int          DEPTH   = 1024,
  parameter int          LATENCY = 1
) (
  input  logic        clk_in,
  input  logic        reset,
  input  logic        req,
  input  logic        we,
  input  logic [1:0]  wsel,
  input  logic [2:0]  lsel,
  input  logic [31:0] addr,
  input  logic [31:0] wdata,
  output logic [31:0] rdata,
  output logic        ready,
  output logic        fault,
  output logic        busy
);
  localparam int          AW   = $clog2(DEPTH);
  localparam logic [31:0] SPAN = 32'(DEPTH * 4);

  typedef enum logic [1:0] {S_IDLE, S_WAIT, S_DONE} state_t;

  state_t      state_q, state_d;
  logic [3:0]  cnt_q, cnt_d;
  logic        ready_q, ready_d;
  logic        fault_q, fault_d;
  logic [31:0] rdata_q, rdata_d;
  logic        we_q, we_d;
  logic [1:0]  wsel_q, wsel_d;
  logic [2:0]  lsel_q, lsel_d;
  logic [31:0] addr_q, addr_d;
  logic [31:0] wdata_q, wdata_d;

  logic [31:0] mem [DEPTH];

  logic          sel_we;
  logic [1:0]    sel_wsel;
  logic [2:0]    sel_lsel;
  logic [31:0]   sel_addr, sel_wdata, off;
  logic          sel_fault, do_access;
  logic [AW-1:0] word_idx;
  logic [31:0]   rd_word, load_val, wr_word;
  logic [3:0]    wr_be;
  logic [7:0]    lane_b;
  logic [15:0]   lane_h;

  // In IDLE the live inputs are decoded (acceptance edge); afterwards the latched copy.
  always_comb begin
    sel_we    = (state_q == S_IDLE) ? we    : we_q;
    sel_wsel  = (state_q == S_IDLE) ? wsel  : wsel_q;
    sel_lsel  = (state_q == S_IDLE) ? lsel  : lsel_q;
    sel_addr  = (state_q == S_IDLE) ? addr  : addr_q;
    sel_wdata = (state_q == S_IDLE) ? wdata : wdata_q;
    off       = sel_addr - BASE;
    word_idx  = off[AW+1:2];
    rd_word   = mem[word_idx];
    lane_b    = 8'(rd_word >> {sel_addr[1:0], 3'b000});
    lane_h    = 16'(rd_word >> {sel_addr[1], 4'b0000});

    sel_fault = (off >= SPAN);
    if (sel_we) begin
      case (sel_wsel)
        2'b00:   sel_fault = sel_fault | (sel_addr[1:0] != 2'b00);
        2'b01:   sel_fault = sel_fault | sel_addr[0];
        2'b10:   sel_fault = sel_fault;
        default: sel_fault = 1'b1;
      endcase
    end else begin
      case (sel_lsel)
        3'b000:         sel_fault = sel_fault | (sel_addr[1:0] != 2'b00);
        3'b001, 3'b010: sel_fault = sel_fault | sel_addr[0];
        3'b011, 3'b100: sel_fault = sel_fault;
        default:        sel_fault = 1'b1;
      endcase
    end

    case (sel_lsel)
      3'b001:  load_val = {{16{lane_h[15]}}, lane_h};
      3'b010:  load_val = {16'h0000, lane_h};
      3'b011:  load_val = {{24{lane_b[7]}}, lane_b};
      3'b100:  load_val = {24'h000000, lane_b};
      default: load_val = rd_word;
    endcase

    case (sel_wsel)
      2'b01: begin
        wr_word = {2{sel_wdata[15:0]}};
        wr_be   = sel_addr[1] ? 4'b1100 : 4'b0011;
      end
      2'b10: begin
        wr_word = {4{sel_wdata[7:0]}};
        wr_be   = 4'b0001 << sel_addr[1:0];
      end
      default: begin
        wr_word = sel_wdata;
        wr_be   = 4'b1111;
      end
    endcase
  end

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    ready_d   = 1'b0;
    fault_d   = fault_q;
    rdata_d   = rdata_q;
    we_d      = we_q;
    wsel_d    = wsel_q;
    lsel_d    = lsel_q;
    addr_d    = addr_q;
    wdata_d   = wdata_q;
    do_access = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (req) begin
          we_d    = we;
          wsel_d  = wsel;
          lsel_d  = lsel;
          addr_d  = addr;
          wdata_d = wdata;
          if (sel_fault) begin
            state_d = S_DONE;
            ready_d = 1'b1;
            fault_d = 1'b1;
            rdata_d = 32'h0;
          end else if (LATENCY == 0) begin
            do_access = 1'b1;
          end else begin
            state_d = S_WAIT;
            cnt_d   = 4'(LATENCY - 1);
          end
        end
      end
      S_WAIT: begin
        if (cnt_q == 4'd0) do_access = 1'b1;
        else cnt_d = cnt_q - 4'd1;
      end
      default: state_d = S_IDLE;
    endcase
    if (do_access) begin
      state_d = S_DONE;
      ready_d = 1'b1;
      fault_d = 1'b0;
      rdata_d = sel_we ? 32'h0 : load_val;
    end
  end

  always_ff @(posedge clk_in) begin
    if (reset) begin
      state_q <= S_IDLE;
      cnt_q   <= 4'd0;
      ready_q <= 1'b0;
      fault_q <= 1'b0;
      rdata_q <= 32'h0;
      we_q    <= 1'b0;
      wsel_q  <= 2'b00;
      lsel_q  <= 3'b000;
      addr_q  <= 32'h0;
      wdata_q <= 32'h0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      ready_q <= ready_d;
      fault_q <= fault_d;
      rdata_q <= rdata_d;
      we_q    <= we_d;
      wsel_q  <= wsel_d;
      lsel_q  <= lsel_d;
      addr_q  <= addr_d;
      wdata_q <= wdata_d;
    end
  end

  // Storage is never reset; reset only suppresses a write that would land this edge.
  always_ff @(posedge clk_in) begin
    if (!reset && do_access && sel_we) begin
      for (int b = 0; b < 4; b++) begin
        if (wr_be[b]) mem[word_idx][b*8 +: 8] <= wr_word[b*8 +: 8];
      end
    end
  end

  assign rdata = rdata_q;
  assign ready = ready_q;
  assign fault = fault_q;
  assign busy  = (state_q != S_IDLE);
endmodule
